// File: rtl/seg_scan_n.sv
// seg_scan_n: N-digit multiplexed 7-segment scanner for a common-anode display.
//
// Each digit gets a slot of SCAN_CMAX cycles. The first DEAD cycles of a slot keep every
// anode off to avoid ghosting. The digit is then lit for on_len cycles, where on_len
// scales the usable part of the slot by (bri+1)/2^BW.
// New content is written into a staging copy with a single-cycle upd. It moves to the
// displayed (shadow) copy only at a frame boundary, so a frame never shows mixed content.
// ack pulses for one cycle when the new content becomes visible.
//
// Ports:
//   clk     system clock
//   rst_n   synchronous active-low reset
//   digits  4*N packed digit values, digit i at [4i+3:4i], digit 0 rightmost
//   blank   per-digit dark mask
//   blink   per-digit mask, digit dark while the blink phase is 1
//   dp      per-digit decimal point
//   bri     brightness, used live every cycle
//   upd     capture request for digits/blank/blink/dp
//   ack     one-cycle pulse when captured content becomes visible
//   seg_n   active-low segments, bit7 = dp, bits6..0 = g..a
//   an_n    active-low anodes, bit i = digit i
module seg_scan_n #(
    parameter int unsigned N            = 8,
    parameter int unsigned SCAN_CMAX    = 100000,
    parameter int unsigned DEAD         = 0,
    parameter int unsigned BW           = 3,
    parameter int unsigned BLINK_FRAMES = 250,
    parameter int unsigned HEX          = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [4*N-1:0] digits,
    input  logic [N-1:0]   blank,
    input  logic [N-1:0]   blink,
    input  logic [N-1:0]   dp,
    input  logic [BW-1:0]  bri,
    input  logic           upd,
    output logic           ack,
    output logic [7:0]     seg_n,
    output logic [N-1:0]   an_n
);

    localparam int unsigned CW  = (SCAN_CMAX > 1) ? $clog2(SCAN_CMAX) : 1;
    localparam int unsigned PW  = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned FW  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    // Wide enough for U*(bri+1) without truncation.
    localparam int unsigned PRW = CW + BW + 1;

    localparam logic [CW-1:0]  CNT_LAST = CW'(SCAN_CMAX - 1);
    localparam logic [PW-1:0]  POS_LAST = PW'(N - 1);
    localparam logic [FW-1:0]  FRM_LAST = FW'(BLINK_FRAMES - 1);
    localparam logic [PRW-1:0] USABLE   = PRW'(SCAN_CMAX - DEAD);
    localparam logic [PRW-1:0] DEAD_W   = PRW'(DEAD);

    // Scan state
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [PW-1:0]  pos_q, pos_d;
    logic [FW-1:0]  frm_q, frm_d;
    logic           phase_q, phase_d;
    logic           pend_q, pend_d;
    logic           ack_q, ack_d;

    // Staging and shadow content
    logic [4*N-1:0] stg_dig_q, stg_dig_d, shd_dig_q, shd_dig_d;
    logic [N-1:0]   stg_blank_q, stg_blank_d, shd_blank_q, shd_blank_d;
    logic [N-1:0]   stg_blink_q, stg_blink_d, shd_blink_q, shd_blink_d;
    logic [N-1:0]   stg_dp_q, stg_dp_d, shd_dp_q, shd_dp_d;

    // Registered outputs
    logic [N-1:0]   an_q, an_d;
    logic [7:0]     seg_q, seg_d;

    logic           fb;
    logic           load;
    logic [3:0]     cur_dig;
    logic [PRW-1:0] on_len;
    logic [PRW-1:0] rel;
    logic           lit;

    // Active-low segments g..a for a 4-bit value; dp is handled separately.
    function automatic logic [6:0] glyph(input logic [3:0] v);
        logic [6:0] g;
        g = 7'h7F;
        case (v)
            4'h0:    g = 7'h40;
            4'h1:    g = 7'h79;
            4'h2:    g = 7'h24;
            4'h3:    g = 7'h30;
            4'h4:    g = 7'h19;
            4'h5:    g = 7'h12;
            4'h6:    g = 7'h02;
            4'h7:    g = 7'h78;
            4'h8:    g = 7'h00;
            4'h9:    g = 7'h10;
            4'hA:    g = (HEX != 0) ? 7'h08 : 7'h7F;
            4'hB:    g = (HEX != 0) ? 7'h03 : 7'h7F;
            4'hC:    g = (HEX != 0) ? 7'h46 : 7'h7F;
            4'hD:    g = (HEX != 0) ? 7'h21 : 7'h7F;
            4'hE:    g = (HEX != 0) ? 7'h06 : 7'h7F;
            default: g = (HEX != 0) ? 7'h0E : 7'h7F;
        endcase
        return g;
    endfunction

    // Scan counters and update handshake
    always_comb begin
        cnt_d       = cnt_q;
        pos_d       = pos_q;
        frm_d       = frm_q;
        phase_d     = phase_q;
        pend_d      = pend_q;
        stg_dig_d   = stg_dig_q;
        stg_blank_d = stg_blank_q;
        stg_blink_d = stg_blink_q;
        stg_dp_d    = stg_dp_q;
        shd_dig_d   = shd_dig_q;
        shd_blank_d = shd_blank_q;
        shd_blink_d = shd_blink_q;
        shd_dp_d    = shd_dp_q;

        fb = (cnt_q == CNT_LAST) && (pos_q == POS_LAST);

        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            pos_d = (pos_q == POS_LAST) ? '0 : pos_q + PW'(1);
        end else begin
            cnt_d = cnt_q + CW'(1);
        end

        if (fb) begin
            if (frm_q == FRM_LAST) begin
                frm_d   = '0;
                phase_d = ~phase_q;
            end else begin
                frm_d = frm_q + FW'(1);
            end
        end

        if (upd) begin
            stg_dig_d   = digits;
            stg_blank_d = blank;
            stg_blink_d = blink;
            stg_dp_d    = dp;
            pend_d      = 1'b1;
        end

        // An upd on the boundary cycle itself is loaded at that same boundary.
        load = fb && (pend_q || upd);
        if (load) begin
            shd_dig_d   = upd ? digits : stg_dig_q;
            shd_blank_d = upd ? blank  : stg_blank_q;
            shd_blink_d = upd ? blink  : stg_blink_q;
            shd_dp_d    = upd ? dp     : stg_dp_q;
            pend_d      = 1'b0;
        end
        ack_d = load;
    end

    // Display decode, from shadow content only
    always_comb begin
        cur_dig = '0;
        for (int i = 0; i < N; i++) begin
            if (pos_q == PW'(i)) begin
                cur_dig = shd_dig_q[4*i +: 4];
            end
        end

        on_len = (USABLE * (PRW'(bri) + PRW'(1))) >> BW;
        // Inside the dead time rel wraps to a value far above any on_len, so a single
        // compare covers both the dead-time and the on-window conditions.
        rel    = PRW'(cnt_q) - DEAD_W;
        lit    = (rel < on_len) && !shd_blank_q[pos_q] && !(shd_blink_q[pos_q] && phase_q);

        an_d  = lit ? ~(N'(1) << pos_q) : '1;
        seg_d = lit ? {~shd_dp_q[pos_q], glyph(cur_dig)} : 8'hFF;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            pos_q       <= '0;
            frm_q       <= '0;
            phase_q     <= 1'b0;
            pend_q      <= 1'b0;
            ack_q       <= 1'b0;
            stg_dig_q   <= '0;
            stg_blank_q <= '1;
            stg_blink_q <= '0;
            stg_dp_q    <= '0;
            shd_dig_q   <= '0;
            shd_blank_q <= '1;
            shd_blink_q <= '0;
            shd_dp_q    <= '0;
            an_q        <= '1;
            seg_q       <= 8'hFF;
        end else begin
            cnt_q       <= cnt_d;
            pos_q       <= pos_d;
            frm_q       <= frm_d;
            phase_q     <= phase_d;
            pend_q      <= pend_d;
            ack_q       <= ack_d;
            stg_dig_q   <= stg_dig_d;
            stg_blank_q <= stg_blank_d;
            stg_blink_q <= stg_blink_d;
            stg_dp_q    <= stg_dp_d;
            shd_dig_q   <= shd_dig_d;
            shd_blank_q <= shd_blank_d;
            shd_blink_q <= shd_blink_d;
            shd_dp_q    <= shd_dp_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
        end
    end

    assign ack   = ack_q;
    assign an_n  = an_q;
    assign seg_n = seg_q;

endmodule
